secded_decoder_pipe: RTL
========================

// Module: secded_decoder_pipe
// PURPOSE
//  Parametrised, pipelined SECDED (extended Hamming) decoder for the UART datapath. Accepts one
//  codeword per cycle over valid/ready and corrects single-bit errors. Flags double-bit errors and
//  outputs the corrected data word. Sits between the receive deserialiser and the memory-mapped RX
//  register file. Optional saturating error counters feed the status registers.
// PARAMETERS
//  DATA_W    8   data bits per word; legal range 4..57
//  PARITY_W  --  localparam: smallest p with 2**p >= DATA_W+p+1 (8->4, 16->5, 32->6)
//  CODE_W    --  localparam: DATA_W+PARITY_W+1 (8->13)
//  CNT_W     16  width of each error counter
// PORTS
//  clk             in   1         rising-edge clock
//  rst             in   1         asynchronous, active-high reset
//  in_valid        in   1         in_code valid
//  in_ready        out  1         decoder can accept in_code this cycle
//  in_code         in   CODE_W    [0]=overall even parity; [i], i>=1 = Hamming position i
//  out_valid       out  1         output word valid
//  out_ready       in   1         consumer accepts output this cycle
//  out_data        out  DATA_W    corrected data; 0 when uncorrectable
//  out_err_corr    out  1         single-bit error was corrected (includes bit 0)
//  out_err_uncorr  out  1         uncorrectable error (double bit, or syndrome >= CODE_W)
//  out_err_pos     out  PARITY_W  flipped position when corr; raw syndrome when uncorr; else 0
//  cnt_clr         in   1         synchronous clear of both counters
//  corr_cnt        out  CNT_W     count of corrected words (saturating)
//  uncorr_cnt      out  CNT_W     count of uncorrectable words (saturating)
// BEHAVIOUR
//  - Code layout: parity bits at power-of-2 positions 1,2,4,...; data bits d0.. fill the remaining
//    positions 3,5,6,7,9,... in ascending order. Bit 0 makes the whole word even parity.
//  - Syndrome bit k = XOR of in_code[i] for all i>=1 with bit k of i set. perr = ^in_code.
//  - Stage 1 registers syndrome, perr and the raw code. Stage 2 corrects, classifies and registers
//    all out_* signals.
//  - Classification:
//      syn==0, perr=0          -> clean
//      syn==0, perr=1          -> corr, pos 0, data unchanged
//      syn!=0, perr=1, syn<CODE_W  -> flip bit syn, corr, pos=syn
//      syn!=0, perr=1, syn>=CODE_W -> uncorr
//      syn!=0, perr=0          -> uncorr (double)
//  - Handshake: a transfer occurs when valid&&ready. Each stage holds a valid flag and advances
//    when its downstream slot is empty or draining this cycle. in_ready = !s1_valid || s1_adv,
//    which is combinational from out_ready through the stage chain.
//  - Timing: latency is 2 cycles from input transfer to out_valid. Throughput is 1 word/cycle
//    while out_ready=1. Outputs are held stable while out_valid && !out_ready.
//  - No word is dropped or duplicated under any backpressure pattern.
//  - Reset: rst clears both stage valids, all out_* to 0 and both counters to 0.
//    in_ready=1 after reset. A reset mid-pipeline discards in-flight words.
//  - Counters: increment on an output transfer (out_valid && out_ready) carrying the matching flag.
//    They saturate at all-ones with no wrap. cnt_clr takes priority over a same-cycle increment.
// CONFIGURATION
//  SECDED_STATS_EN defined:
//    corr_cnt and uncorr_cnt are implemented as described above.
//  SECDED_STATS_EN undefined:
//    counter registers are not built. corr_cnt and uncorr_cnt are tied to 0 and cnt_clr is
//    ignored. Decode path is identical.
// TESTING (DATA_W=8, CODE_W=13; 0xA5 encodes to 0x144E)
//  1. Clean word: 0x144E, out_ready=1
//     -> 2 cycles later out_data=0xA5, corr=0, uncorr=0, pos=0.
//  2. Single-bit error at position 6: 0x140E
//     -> out_data=0xA5, corr=1, pos=6; corr_cnt increments by 1.
//  3. Overall-parity bit error: 0x144F
//     -> out_data=0xA5, corr=1, pos=0.
//     Double-bit error at positions 3 and 5: 0x1466
//     -> out_data=0x00, uncorr=1, pos=6; uncorr_cnt increments by 1.
//  4. Backpressure: stream 10 distinct words with in_valid=1 and out_ready toggling 1,0,0,1...
//     -> all 10 words emerge in order; outputs stable while stalled; in_ready=0 when both stages
//        are full and out_ready=0.
//  5. Counter saturation, CNT_W=2: drive 5 corrected words -> corr_cnt=3.
//     Then assert cnt_clr together with a corrected output transfer -> corr_cnt=0.
//  6. Reset mid-stream: assert rst with 2 words in flight
//     -> out_valid=0 and all counters 0 immediately; the next word after release decodes
//        correctly with 2-cycle latency.

Source files
------------

// File: rtl/secded_decoder_pipe_if.sv
// Codeword-in / corrected-word-out bus of the SECDED decoder.
// slave = decoder side, master = producer/consumer side.
// Widths derive from DATA_W exactly as in the decoder.
interface secded_decoder_pipe_if #(
  parameter int DATA_W = 8
);

  function automatic int calc_parity_w(int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  localparam int PARITY_W = calc_parity_w(DATA_W);
  localparam int CODE_W   = DATA_W + PARITY_W + 1;

  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_err_corr;
  logic                out_err_uncorr;
  logic [PARITY_W-1:0] out_err_pos;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_err_corr, out_err_uncorr, out_err_pos
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_err_corr, out_err_uncorr, out_err_pos
  );

endinterface

// File: rtl/secded_decoder_pipe.sv
// Pipelined extended-Hamming (SECDED) decoder; optional error counters under SECDED_STATS_EN.
// Latency: 2 cycles input transfer to out_valid; 1 word/cycle while out_ready is high.
// Backpressure: stages advance only into an empty/draining slot; in_ready is combinational from out_ready.
module secded_decoder_pipe #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  secded_decoder_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);

  function automatic int calc_parity_w(int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  // Hamming position of data bit k: k-th non-power-of-two position >= 3.
  function automatic int data_pos(int k);
    int n;
    int p;
    n = 0;
    p = 0;
    for (int i = 3; i < 128; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (n == k && p == 0) p = i;
        n++;
      end
    end
    return p;
  endfunction

  localparam int PARITY_W = calc_parity_w(DATA_W);
  localparam int CODE_W   = DATA_W + PARITY_W + 1;

  logic [PARITY_W-1:0] syn_c;
  logic [DATA_W-1:0]   dat_c;
  logic                s1_valid;
  logic                s1_perr;
  logic [PARITY_W-1:0] s1_syn;
  logic [DATA_W-1:0]   s1_dat;
  logic                s1_adv;
  logic                flip_c;
  logic                corr_c;
  logic                uncorr_c;
  logic [PARITY_W-1:0] pos_c;
  logic [DATA_W-1:0]   fixed_c;

  assign s1_adv       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;

  // Syndrome: XOR of the position indices of every set bit above bit 0.
  always_comb begin
    syn_c = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (bus.in_code[i]) syn_c = syn_c ^ PARITY_W'(i);
    end
  end

  // Parity positions are dead once the syndrome is formed, so only data bits travel to stage 2.
  for (genvar k = 0; k < DATA_W; k++) begin : g_dat
    localparam int POS = data_pos(k);
    assign dat_c[k]   = bus.in_code[POS];
    assign fixed_c[k] = s1_dat[k] ^ (flip_c && (int'(s1_syn) == POS));
  end

  // Stage 1: capture syndrome, overall parity and data bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_perr  <= 1'b0;
      s1_syn   <= '0;
      s1_dat   <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_syn  <= syn_c;
        s1_perr <= ^bus.in_code;
        s1_dat  <= dat_c;
      end
    end
  end

  // Classify the stage-1 word: clean, correctable (incl. bit 0) or uncorrectable.
  always_comb begin
    flip_c   = 1'b0;
    corr_c   = 1'b0;
    uncorr_c = 1'b0;
    pos_c    = '0;
    if (s1_syn == '0) begin
      corr_c = s1_perr;
    end else if (s1_perr && (int'(s1_syn) < CODE_W)) begin
      flip_c = 1'b1;
      corr_c = 1'b1;
      pos_c  = s1_syn;
    end else begin
      uncorr_c = 1'b1;
      pos_c    = s1_syn;
    end
  end

  // Stage 2: register corrected word and flags; hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_data       <= '0;
      bus.out_err_corr   <= 1'b0;
      bus.out_err_uncorr <= 1'b0;
      bus.out_err_pos    <= '0;
    end else if (s1_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data       <= uncorr_c ? '0 : fixed_c;
        bus.out_err_corr   <= corr_c;
        bus.out_err_uncorr <= uncorr_c;
        bus.out_err_pos    <= pos_c;
      end
    end
  end

`ifdef SECDED_STATS_EN
  logic out_xfer;
  assign out_xfer = bus.out_valid && bus.out_ready;

  // Saturating error counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (out_xfer && bus.out_err_corr && (corr_cnt != '1))
        corr_cnt <= corr_cnt + 1'b1;
      if (out_xfer && bus.out_err_uncorr && (uncorr_cnt != '1))
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule
